// File: rtl/case_9_pkg.sv
// Shared types and default sizing for the case_9 multiply-accumulate stage.
// Count width is derived from the block length so it can hold LEN itself.
package case_9_pkg;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  localparam int DEF_DIN0_W = 4;
  localparam int DEF_DIN1_W = 2;
  localparam int DEF_PROD_W = 4;
  localparam int DEF_ACC_W  = 12;
  localparam int DEF_LEN    = 8;

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_LEN);

endpackage

// File: rtl/case_9_mac_mul.sv
// Combinational signed multiply keeping only the low PROD_W product bits.
// The low bits of a product depend only on the low bits of the operands.
module case_9_mac_mul #(
  parameter int DIN0_W = 4,
  parameter int DIN1_W = 2,
  parameter int PROD_W = 4
) (
  input  logic [DIN0_W-1:0] a_i,
  input  logic [DIN1_W-1:0] b_i,
  output logic [PROD_W-1:0] p_o
);

  logic [PROD_W-1:0] a_t;
  logic [PROD_W-1:0] b_t;

  // Sign-extend (or truncate) each operand to the product width first.
  if (DIN0_W >= PROD_W) begin : g_a_trunc
    assign a_t = a_i[PROD_W-1:0];
  end else begin : g_a_ext
    assign a_t = {{(PROD_W-DIN0_W){a_i[DIN0_W-1]}}, a_i};
  end

  if (DIN1_W >= PROD_W) begin : g_b_trunc
    assign b_t = b_i[PROD_W-1:0];
  end else begin : g_b_ext
    assign b_t = {{(PROD_W-DIN1_W){b_i[DIN1_W-1]}}, b_i};
  end

  assign p_o = a_t * b_t;

endmodule

// File: rtl/case_9_mac_acc.sv
// Accumulates LEN truncated signed products per block and hands the sum
// (plus a sticky overflow flag) to a valid/ready sink.
module case_9_mac_acc
  import case_9_pkg::*;
#(
  parameter int DIN0_W = DEF_DIN0_W,
  parameter int DIN1_W = DEF_DIN1_W,
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN    = DEF_LEN
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DIN0_W-1:0] din0,
  input  logic signed [DIN1_W-1:0] din1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_ovf
);

  localparam int CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               p_vld_q, p_vld_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic               out_ovf_q, out_ovf_d;

  logic [PROD_W-1:0]  mul_p;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;
  logic               add_ovf;
  logic               accept;

  case_9_mac_mul #(
    .DIN0_W (DIN0_W),
    .DIN1_W (DIN1_W),
    .PROD_W (PROD_W)
  ) u_mul (
    .a_i (din0),
    .b_i (din1),
    .p_o (mul_p)
  );

  if (ACC_W > PROD_W) begin : g_prod_sext
    assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
  end else begin : g_prod_same
    assign prod_ext = prod_q;
  end

  assign sum     = acc_q + prod_ext;
  // Two's-complement overflow: like-signed operands yielding an opposite-signed sum.
  assign add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);

  assign in_ready  = (state_q == ST_ACC) && (issue_cnt_q < LEN_C) && !ap_rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_OUT);
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    done_cnt_d  = done_cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    prod_d      = prod_q;
    p_vld_d     = accept;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;

    if (accept) begin
      issue_cnt_d = issue_cnt_q + ONE_C;
      prod_d      = mul_p;
    end

    if (p_vld_q) begin
      acc_d      = sum;
      done_cnt_d = done_cnt_q + ONE_C;
      ovf_d      = ovf_q | add_ovf;
      if (done_cnt_q == LAST_C) begin
        state_d   = ST_OUT;
        out_acc_d = sum;
        out_ovf_d = ovf_q | add_ovf;
      end
    end

    // Result taken: rearm for the next block; the presented result stays put.
    if ((state_q == ST_OUT) && out_ready) begin
      state_d     = ST_ACC;
      issue_cnt_d = '0;
      done_cnt_d  = '0;
      acc_d       = '0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= ST_ACC;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      prod_q      <= '0;
      p_vld_q     <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      done_cnt_q  <= done_cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      prod_q      <= prod_d;
      p_vld_q     <= p_vld_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_case_9_mac_acc.sv
// Directed bench for case_9_mac_acc: a 12-bit and a 4-bit accumulator share
// stimulus; an integer model fills a scoreboard checked at each block result.
module tb_case_9_mac_acc;

  localparam int LEN = 8;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic signed [3:0] din0 = '0;
  logic signed [1:0] din1 = '0;

  logic               in_ready, out_valid, out_ovf;
  logic signed [11:0] out_acc;
  logic               in_ready_w4, out_valid_w4, out_ovf_w4;
  logic signed [3:0]  out_acc_w4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] acc12;
    logic        ovf12;
    logic [3:0]  acc4;
    logic        ovf4;
  } exp_t;

  exp_t sb_q[$];

  int m_acc12 = 0;
  int m_acc4  = 0;
  bit m_ovf12 = 0;
  bit m_ovf4  = 0;
  int m_cnt   = 0;

  always #5 ap_clk = ~ap_clk;

  case_9_mac_acc dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  case_9_mac_acc #(.ACC_W(4)) dut_w4 (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w4),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid_w4),
    .out_ready (out_ready),
    .out_acc   (out_acc_w4),
    .out_ovf   (out_ovf_w4)
  );

  function automatic int wrapw(input int v, input int w);
    int m;
    int r;
    m = 1 << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_acc12 = 0; m_acc4 = 0; m_ovf12 = 0; m_ovf4 = 0; m_cnt = 0;
  endtask

  task automatic model_add(input int a, input int b);
    int p;
    int s;
    exp_t e;
    p = wrapw(a * b, 4);
    s = m_acc12 + p;
    if (s > 2047 || s < -2048) m_ovf12 = 1;
    m_acc12 = wrapw(s, 12);
    s = m_acc4 + p;
    if (s > 7 || s < -8) m_ovf4 = 1;
    m_acc4 = wrapw(s, 4);
    m_cnt++;
    if (m_cnt == LEN) begin
      e.acc12 = 12'(m_acc12);
      e.ovf12 = m_ovf12;
      e.acc4  = 4'(m_acc4);
      e.ovf4  = m_ovf4;
      sb_q.push_back(e);
      model_clear();
    end
  endtask

  // Entered and left at posedge+1; the accept is the posedge after in_ready is seen.
  task automatic send(input int a, input int b, input int gap);
    int guard;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge ap_clk); #1; end
    end
    in_valid = 1'b1;
    din0 = 4'(a);
    din1 = 2'(b);
    guard = 0;
    forever begin
      @(negedge ap_clk);
      if (in_ready) break;
      guard++;
      if (guard > 50) begin
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge ap_clk); #1;
        return;
      end
    end
    @(posedge ap_clk); #1;
    $display("send din0=%0d din1=%0d", a, b);
    model_add(a, b);
  endtask

  task automatic run_block(input int a, input int b, input int gap_max, input bit keep);
    for (int i = 0; i < LEN; i++)
      send(a, b, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic zeros_plus(input int a, input int b);
    for (int i = 0; i < LEN - 1; i++) send(0, 0, 0);
    send(a, b, 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input bit check_lat, input bit do_hs);
    int n;
    exp_t e;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!out_valid && n < 20);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_valid_w4", {31'd0, out_valid_w4}, 32'd1);
    if (check_lat) chk("latency", n, 32'd2);
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL sb_pop: observed=empty expected=entry");
    end
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    $display("result acc12=%0d ovf12=%0b acc4=%0d ovf4=%0b (exp %0d %0b %0d %0b)",
             out_acc, out_ovf, out_acc_w4, out_ovf_w4,
             $signed(e.acc12), e.ovf12, $signed(e.acc4), e.ovf4);
    chk("acc12", {20'd0, out_acc}, {20'd0, e.acc12});
    chk("ovf12", {31'd0, out_ovf}, {31'd0, e.ovf12});
    chk("acc4", {28'd0, out_acc_w4}, {28'd0, e.acc4});
    chk("ovf4", {31'd0, out_ovf_w4}, {31'd0, e.ovf4});
    if (do_hs) begin
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
      @(negedge ap_clk);
      chk("hs_out_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
      chk("hs_in_ready_w4", {31'd0, in_ready_w4}, 32'd1);
      chk("hs_acc_held", {20'd0, out_acc}, {20'd0, e.acc12});
      @(posedge ap_clk); #1;
    end
  endtask

  initial begin
    // Asynchronous reset asserted mid-cycle clears outputs without a clock edge.
    #3 ap_rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_acc", {20'd0, out_acc}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic back-to-back block.
    run_block(3, 1, 0, 0);
    wait_result(1, 1);

    // Truncation of single products.
    zeros_plus(-8, -2);
    wait_result(1, 1);
    zeros_plus(7, -2);
    wait_result(1, 1);
    run_block(7, -2, 0, 0);
    wait_result(1, 1);
    zeros_plus(-8, 1);
    wait_result(1, 1);

    // Backpressure with in_valid held high through the OUT state.
    run_block(2, 1, 0, 1);
    din0 = 4'sd1;
    din1 = 2'sd1;
    wait_result(1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_acc", {20'd0, out_acc}, 32'd16);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
    run_block(1, 1, 0, 0);
    wait_result(1, 1);

    // Overflow visible on the 4-bit instance, then cleared by a clean block.
    run_block(7, 1, 3, 0);
    wait_result(1, 1);
    run_block(-1, 1, 3, 0);
    wait_result(1, 1);

    // Reset after three accepts discards the partial sum.
    for (int i = 0; i < 3; i++) send(2, 1, int'($urandom_range(0, 3)));
    in_valid = 1'b0;
    #2 ap_rst = 1'b1;
    #1;
    chk("mid_rst_out_acc", {20'd0, out_acc}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    model_clear();
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ap_clk);
      chk("mid_rst_no_out", {31'd0, out_valid}, 32'd0);
    end
    @(posedge ap_clk); #1;
    run_block(1, 1, 2, 0);
    wait_result(1, 1);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/case_9_mac_acc.md
Name: case_9_mac_acc

Overview:
- Downstream stage of the case_9 signed multiplier datapath.
- Accepts operand pairs on a valid/ready stream, forms the truncated signed product, and accumulates LEN products into a signed sum.
- Emits one accumulated result per block on a valid/ready output, with a sticky overflow flag.
- Sits between the operand source and the result sink in the case_9 kernel.

Parameters:
- DIN0_W, 4, signed width of din0
- DIN1_W, 2, signed width of din1
- PROD_W, 4, product width; the full product is truncated to its low PROD_W bits
- ACC_W, 12, signed accumulator width (ACC_W >= PROD_W)
- LEN, 8, products per block (>= 2)

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- din0  in  DIN0_W  signed operand 0
- din1  in  DIN1_W  signed operand 1
- out_valid  out  1  block result valid
- out_ready  in  1  sink accepts the result
- out_acc  out  ACC_W  signed accumulated sum
- out_ovf  out  1  signed overflow occurred during this block (sticky)

Behaviour:
- Reset: one clock (ap_clk); reset is asynchronous and active-high (ap_rst).
  - All registers clear: acc=0, issue count=0, done count=0, p_vld=0, ovf=0, state=ACC.
  - out_valid=0, out_acc=0, out_ovf=0.
  - in_ready=0 while ap_rst is high.
- FSM states: ACC and OUT.
- in_ready = (state==ACC) && (issue_cnt < LEN) && !ap_rst. An accept occurs when in_valid && in_ready; issue_cnt increments on each accept.
- Stage 1 (product):
  - On accept, prod_r <= low PROD_W bits of signed(din0)*signed(din1), and p_vld <= 1.
  - Otherwise p_vld <= 0.
- Stage 2 (accumulate):
  - When p_vld, acc <= acc + sign-extend(prod_r) to ACC_W, with two's-complement wrap.
  - done_cnt increments on the same cycle.
  - ovf |= signed overflow of that add: operand signs equal and result sign differs.
- ACC -> OUT: on the cycle where p_vld is high and done_cnt == LEN-1.
- Latency:
  - Last accept in cycle t; out_valid is high from cycle t+2.
  - out_acc = acc and out_ovf = ovf; both are registered and held stable while out_valid && !out_ready.
- OUT -> ACC: on out_valid && out_ready.
  - acc, issue_cnt, done_cnt and ovf clear.
  - in_ready is high the next cycle.
- out_acc and out_ovf:
  - Hold their value after the handshake until the next block completes.
  - out_valid drops in the cycle after the handshake.
- Gaps in in_valid stretch the block but do not change the result.
- in_valid during OUT, or after LEN accepts, is ignored: no accept, no state change.
- Reset mid-block discards the partial sum. The next block starts from zero.

Decomposition:
- Shared package case_9_pkg:
  - State enum {ACC, OUT}.
  - Default widths (DIN0_W, DIN1_W, PROD_W, ACC_W, LEN).
  - Count width constant clog2(LEN+1).
- One natural sub-module: case_9_mac_mul.
  - Combinational signed multiply, DIN0_W x DIN1_W, truncated to PROD_W.
  - Instantiated ahead of the stage-1 register.
- FSM, counters and accumulator stay in the top module.

Test Plan:
1. Reset: assert ap_rst mid-cycle, asynchronously.
   - out_valid=0, out_acc=0, out_ovf=0, in_ready=0 immediately.
   - After release, in_ready=1 on the next cycle.
2. Basic block: 8 accepts of din0=3, din1=1, back-to-back.
   - out_valid rises 2 cycles after the 8th accept.
   - out_acc=24, out_ovf=0.
3. Truncation: single products checked via a block of 7 zeros plus one test pair.
   - din0=-8, din1=-2 gives product 0 → out_acc=0.
   - din0=7, din1=-2 gives product 2 (-14 truncated).
   - A block of 8 of these gives out_acc=16.
   - din0=-8, din1=1 gives -8.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 throughout.
   - out_valid and out_acc stay stable; in_ready=0; no accept.
   - After out_ready=1, in_ready=1 the next cycle.
   - The next block of 8× (1×1) gives 8.
5. Overflow, ACC_W=4: 8× (7×1).
   - out_acc = 4'b1000 (-8), out_ovf=1.
   - out_ovf clears for a following non-overflowing block.
6. Reset mid-block: reset after 3 accepts, with in_valid gaps of random length.
   - No out_valid.
   - The next block of 8× (1×1) gives out_acc=8.
